// File: rtl/cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Performs WIDTH-bit add/subtract (WIDTH = 4*NIBBLES) using one external
// 4-bit carry look-ahead slice. It feeds the slice one nibble per cycle,
// LSB first, and carries the slice carry-out forward as the next nibble's
// carry-in.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand request
//   in_ready   : operands accepted (high only in IDLE)
//   a, b       : WIDTH-bit operands
//   cin        : carry-in (add) / borrow-in (sub)
//   sub        : 0 = a+b+cin, 1 = a-b-cin
//   out_valid  : result available (DONE)
//   out_ready  : consumer accepts result
//   sum        : WIDTH-bit result (0 outside DONE)
//   cout       : raw MSB carry-out; for sub, 1 = no borrow
//   overflow   : two's-complement overflow
//   cla_a/b    : nibble operands to the slice (0 outside RUN)
//   cla_cin    : slice carry-in (0 outside RUN)
//   cla_sum    : slice sum (combinational from cla_* outputs)
//   cla_cout   : slice carry-out (combinational from cla_* outputs)
// ---------------------------------------------------------------------------
module cla_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   overflow,
   output logic [3:0]             cla_a,
   output logic [3:0]             cla_b,
   output logic                   cla_cin,
   input  logic [3:0]             cla_sum,
   input  logic                   cla_cout
);

   localparam int WIDTH = 4 * NIBBLES;
   localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg;
   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic [WIDTH-1:0]  sum_reg;
   logic              carry_reg;
   logic [IW-1:0]     idx_reg;
   logic              sign_a_reg;
   logic              sign_b_reg;

   // Subtraction is a + ~b + 1; the borrow-in flips the injected carry.
   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH-1:0]  sum_next;

   assign b_eff = sub ? ~b : b;

   // Slice results enter from the top so that after NIBBLES shifts the
   // first (least significant) nibble has reached bit 0.
   generate
      if (NIBBLES == 1) begin : g_single
         assign sum_next = cla_sum;
      end else begin : g_multi
         assign sum_next = {cla_sum, sum_reg[WIDTH-1:4]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         sum_reg    <= '0;
         carry_reg  <= 1'b0;
         idx_reg    <= '0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b_eff;
                  sum_reg    <= '0;
                  carry_reg  <= cin ^ sub;
                  idx_reg    <= '0;
                  sign_a_reg <= a[WIDTH-1];
                  sign_b_reg <= b_eff[WIDTH-1];
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> 4;
               b_reg     <= b_reg >> 4;
               sum_reg   <= sum_next;
               carry_reg <= cla_cout;
               idx_reg   <= idx_reg + IW'(1);
               if (idx_reg == LAST_IDX) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state, so they change only on
   // clock edges and are forced to zero outside their active phase.
   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);

   assign cla_a   = (state_reg == RUN) ? a_reg[3:0] : 4'd0;
   assign cla_b   = (state_reg == RUN) ? b_reg[3:0] : 4'd0;
   assign cla_cin = (state_reg == RUN) && carry_reg;

   assign sum      = (state_reg == DONE) ? sum_reg : '0;
   assign cout     = (state_reg == DONE) && carry_reg;
   assign overflow = (state_reg == DONE) &&
                     (sign_a_reg == sign_b_reg) &&
                     (sum_reg[WIDTH-1] != sign_a_reg);

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_nibble_sequencer
//
// Drives operations through cla_nibble_sequencer (NIBBLES=4) with a
// behavioural 4-bit slice attached. Expected results come from a full-width
// reference model, are queued when an operation is driven and are popped
// and compared when the result appears.
// ---------------------------------------------------------------------------
module tb_cla_nibble_sequencer;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;
   logic [3:0]    cla_a;
   logic [3:0]    cla_b;
   logic          cla_cin;
   logic [3:0]    cla_sum;
   logic          cla_cout;

   cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .cla_a     (cla_a),
      .cla_b     (cla_b),
      .cla_cin   (cla_cin),
      .cla_sum   (cla_sum),
      .cla_cout  (cla_cout)
   );

   // Behavioural carry look-ahead slice.
   assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] seen_a   [NIB];
   logic       seen_cin [NIB];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                      input logic tc, input logic ts);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   r;
      be  = ts ? ~tb_v : tb_v;
      r   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, tc ^ ts};
      e.s = r[W-1:0];
      e.c = r[W];
      e.v = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
      return e;
   endfunction

   // One full operation. With hold=1 the result is back-pressured for 10
   // cycles while in_valid is kept asserted with junk operands.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input bit hold);
      int   guard;
      int   lat;
      exp_t e;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      a         = ta;
      b         = tb_v;
      cin       = tc;
      sub       = ts;
      in_valid  = 1'b1;
      out_ready = !hold;
      sb.push_back(ref_model(ta, tb_v, tc, ts));
      @(negedge clk);
      if (hold) begin
         a = ~ta;
         b = ~tb_v;
      end else begin
         in_valid = 1'b0;
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (lat < NIB) begin
            seen_a[lat]   = cla_a;
            seen_cin[lat] = cla_cin;
         end
         chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, NIB);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '0;
      chk("sum", {16'd0, sum}, {16'd0, e.s});
      chk("cout", {31'd0, cout}, {31'd0, e.c});
      chk("overflow", {31'd0, overflow}, {31'd0, e.v});
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, e.s});
            chk("hold_cout", {31'd0, cout}, {31'd0, e.c});
            chk("hold_ovf", {31'd0, overflow}, {31'd0, e.v});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         end
         out_ready = 1'b1;
         in_valid  = 1'b0;
      end
      @(negedge clk);
      chk("release_valid", {31'd0, out_valid}, 32'd0);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      if (hold) begin
         @(negedge clk);
         chk("no_capture", {31'd0, in_ready}, 32'd1);
         chk("sb_empty", sb.size(), 32'd0);
      end
      $display("op a=%h b=%h cin=%0d sub=%0d hold=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               ta, tb_v, tc, ts, hold, e.s, e.c, e.v, lat);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add and nibble ordering.
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      chk("cla_a0", {28'd0, seen_a[0]}, 32'd4);
      chk("cla_a1", {28'd0, seen_a[1]}, 32'd3);
      chk("cla_a2", {28'd0, seen_a[2]}, 32'd2);
      chk("cla_a3", {28'd0, seen_a[3]}, 32'd1);
      chk("cla_cin_add", {28'd0, seen_cin[0], seen_cin[1], seen_cin[2], seen_cin[3]}, 32'h0);

      // Carry ripple across nibbles.
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("cla_cin_chain", {28'd0, seen_cin[0], seen_cin[1], seen_cin[2], seen_cin[3]}, 32'b0111);

      // Overflow cases.
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

      // Subtract.
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);

      // Backpressure with busy in_valid pulses.
      do_op(16'hA5C3, 16'h1E2F, 1'b1, 1'b0, 1'b1);

      // A few random operations.
      for (int i = 0; i < 6; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end

      // Reset during the second RUN cycle discards the operation.
      while (!in_ready) @(negedge clk);
      a         = 16'h1234;
      b         = 16'h4321;
      cin       = 1'b0;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_run_cla_a", {28'd0, cla_a}, 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_outs", {15'd0, sum, cout}, 32'd0);
      chk("midrst_ovf", {31'd0, overflow}, 32'd0);
      chk("midrst_cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle sequencer that performs WIDTH-bit add/subtract operations with a single external 4-bit carry look-ahead slice (`carry_look_ahead`). It feeds the slice one nibble per cycle, LSB first, and registers the slice carry-out as the next nibble's carry-in. A valid/ready handshake sits on both the operand side and the result side. It sits between the operand register file and result consumers wherever a full-width CLA is too costly.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operation; WIDTH = 4*NIBBLES; legal range 1..16.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: block accepts operands; high only in IDLE.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in when sub=0; borrow-in when sub=1.
- `sub` input 1: 0 = A+B+cin; 1 = A-B-cin.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: result.
- `cout` output 1: raw carry out of MSB nibble; for sub, 1 = no borrow.
- `overflow` output 1: two's-complement overflow.
- `cla_a`, `cla_b` output 4: nibble operands to the slice.
- `cla_cin` output 1: slice carry-in.
- `cla_sum` input 4: slice sum.
- `cla_cout` input 1: slice carry-out; treated as combinational from `cla_*` outputs within one cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - Capture `a_reg`=a and `b_reg`=(sub ? ~b : b).
  - Set `carry_reg`=cin^sub, `idx`=0, and `sign_a`/`sign_b` = MSBs of a and b_eff.
  - Go to RUN. With `in_valid`=0, stay in IDLE.
- RUN:
  - Slice drive: `cla_a`=a_reg[3:0], `cla_b`=b_reg[3:0], `cla_cin`=carry_reg.
  - Each cycle: a_reg and b_reg shift right by 4; `cla_sum` enters `sum_reg` from the top with a right shift by 4; `carry_reg`<=`cla_cout`; `idx`++.
  - When `idx`==NIBBLES-1 at the edge, go to DONE.
  - `in_valid` is ignored in RUN.
- DONE:
  - Outputs: `out_valid`=1, `sum`=sum_reg, `cout`=carry_reg, `overflow`=(sign_a==sign_b)&&(sum_reg[WIDTH-1]!=sign_a).
  - Outputs hold stable while `out_ready`=0.
  - On `out_ready`=1, go to IDLE; `out_valid` drops next cycle.
- `cla_a`, `cla_b` and `cla_cin` are 0 outside RUN.
- `sum`, `cout` and `overflow` are 0 outside DONE.
- Arithmetic is modulo 2^WIDTH with no saturation; `cout` and `overflow` are reported independently.

## Timing
- Reset, on any edge with `rst_n`=0 regardless of state:
  - State = IDLE, `idx`=0.
  - All registers cleared.
  - Outputs next cycle: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0, `cla_*`=0.
  - Reset mid-RUN or mid-DONE discards the operation with no partial result.
- Accept at edge E0. RUN spans cycles E0..E0+NIBBLES-1, one nibble per cycle. `out_valid` rises after edge E0+NIBBLES.
- Latency from accept to `out_valid`: NIBBLES cycles. Minimum spacing between accepts: NIBBLES+2 cycles.
- NIBBLES=1: a single RUN cycle.
- `out_ready` held high before DONE: result is accepted in its first DONE cycle, so DONE lasts exactly 1 cycle.
- `in_ready` is low from the cycle after accept until the cycle after result acceptance.

## Test plan
- NIBBLES=4, add:
  - a=0x1234, b=0x4321, cin=0, out_ready=1 → sum=0x5555, cout=0, overflow=0; out_valid exactly 4 cycles after accept.
  - Check cla_a sequence 4,3,2,1 and cla_cin all 0.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0; cla_cin sequence 0,1,1,1.
- Overflow:
  - a=0x7FFF, b=0x0001 → sum=0x8000, overflow=1, cout=0.
  - a=0x8000, b=0x8000 → sum=0x0000, overflow=1, cout=1.
- Subtract:
  - sub=1, a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=0.
  - sub=1, a=0x0007, b=0x0005, cin=1 → sum=0x0001, cout=1.
- Backpressure and busy rejection:
  - Hold out_ready=0 for 10 cycles → out_valid, sum, cout and overflow stay stable; in_ready=0 throughout.
  - in_valid pulses during RUN and DONE are not captured.
  - out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, all outputs 0. A new op, 0x0001+0x0001, then gives 0x0002.
